// File: rtl/ps2_keyboard_to_ascii.sv
// PS/2 keyboard receiver: conditions the device-driven clock/data lines,
// assembles 11-bit frames, decodes Set-2 scan codes and emits 7-bit ASCII
// with a one-cycle strobe.
module ps2_keyboard_to_ascii #(
  parameter int unsigned CLK_FREQ        = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned IDLE_US         = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [6:0] ascii_code,
  output logic       ascii_new
);

  localparam int unsigned IDLE_CYCLES = IDLE_US * (CLK_FREQ / 1_000_000);
  localparam int unsigned IDLE_W      = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned DEB_W       = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {NORMAL, BREAK, EXT, EXT_BREAK} state_t;

  logic [1:0]        clk_sync, data_sync;
  logic [DEB_W-1:0]  clk_cnt, data_cnt;
  logic              clk_filt, data_filt, clk_filt_q;
  logic              fall_c;
  logic [10:0]       frame;
  logic [3:0]        bit_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              byte_valid;
  logic [7:0]        byte_code;
  logic [7:0]        key_c;
  state_t            state, state_n;
  logic              shift_flag, shift_n, ctrl_flag, ctrl_n;
  logic [6:0]        code_n;
  logic              new_n;

  // Returns {hit, ascii} for a make code given the current modifiers.
  function automatic logic [7:0] map_key(input logic [7:0] code, input logic shift,
                                         input logic ctrl);
    logic [6:0] lo, hi;
    logic       hit, letter;
    hit = 1'b1;
    lo  = '0;
    hi  = '0;
    case (code)
      8'h1C: {lo, hi} = {7'h41, 7'h41};
      8'h32: {lo, hi} = {7'h42, 7'h42};
      8'h21: {lo, hi} = {7'h43, 7'h43};
      8'h23: {lo, hi} = {7'h44, 7'h44};
      8'h24: {lo, hi} = {7'h45, 7'h45};
      8'h2B: {lo, hi} = {7'h46, 7'h46};
      8'h34: {lo, hi} = {7'h47, 7'h47};
      8'h33: {lo, hi} = {7'h48, 7'h48};
      8'h43: {lo, hi} = {7'h49, 7'h49};
      8'h3B: {lo, hi} = {7'h4A, 7'h4A};
      8'h42: {lo, hi} = {7'h4B, 7'h4B};
      8'h4B: {lo, hi} = {7'h4C, 7'h4C};
      8'h3A: {lo, hi} = {7'h4D, 7'h4D};
      8'h31: {lo, hi} = {7'h4E, 7'h4E};
      8'h44: {lo, hi} = {7'h4F, 7'h4F};
      8'h4D: {lo, hi} = {7'h50, 7'h50};
      8'h15: {lo, hi} = {7'h51, 7'h51};
      8'h2D: {lo, hi} = {7'h52, 7'h52};
      8'h1B: {lo, hi} = {7'h53, 7'h53};
      8'h2C: {lo, hi} = {7'h54, 7'h54};
      8'h3C: {lo, hi} = {7'h55, 7'h55};
      8'h2A: {lo, hi} = {7'h56, 7'h56};
      8'h1D: {lo, hi} = {7'h57, 7'h57};
      8'h22: {lo, hi} = {7'h58, 7'h58};
      8'h35: {lo, hi} = {7'h59, 7'h59};
      8'h1A: {lo, hi} = {7'h5A, 7'h5A};
      8'h45: {lo, hi} = {7'h30, 7'h29};
      8'h16: {lo, hi} = {7'h31, 7'h21};
      8'h1E: {lo, hi} = {7'h32, 7'h40};
      8'h26: {lo, hi} = {7'h33, 7'h23};
      8'h25: {lo, hi} = {7'h34, 7'h24};
      8'h2E: {lo, hi} = {7'h35, 7'h25};
      8'h36: {lo, hi} = {7'h36, 7'h5E};
      8'h3D: {lo, hi} = {7'h37, 7'h26};
      8'h3E: {lo, hi} = {7'h38, 7'h2A};
      8'h46: {lo, hi} = {7'h39, 7'h28};
      8'h0E: {lo, hi} = {7'h60, 7'h7E};
      8'h4E: {lo, hi} = {7'h2D, 7'h5F};
      8'h55: {lo, hi} = {7'h3D, 7'h2B};
      8'h5D: {lo, hi} = {7'h5C, 7'h7C};
      8'h54: {lo, hi} = {7'h5B, 7'h7B};
      8'h5B: {lo, hi} = {7'h5D, 7'h7D};
      8'h4C: {lo, hi} = {7'h3B, 7'h3A};
      8'h52: {lo, hi} = {7'h27, 7'h22};
      8'h41: {lo, hi} = {7'h2C, 7'h3C};
      8'h49: {lo, hi} = {7'h2E, 7'h3E};
      8'h4A: {lo, hi} = {7'h2F, 7'h3F};
      8'h29: {lo, hi} = {7'h20, 7'h20};
      8'h5A: {lo, hi} = {7'h0D, 7'h0D};
      8'h66: {lo, hi} = {7'h5F, 7'h5F};
      8'h76: {lo, hi} = {7'h1B, 7'h1B};
      8'h0D: {lo, hi} = {7'h09, 7'h09};
      default: hit = 1'b0;
    endcase
    // Only letters map to 'A'..'Z' unshifted, so this identifies them.
    letter = (lo >= 7'h41) && (lo <= 7'h5A);
    map_key = {hit, (ctrl && letter) ? lo - 7'h40 : (shift ? hi : lo)};
  endfunction

  // Two-flop synchronizers for both PS/2 lines (idle high).
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Filters: a line flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_filt  <= 1'b1;
      data_filt <= 1'b1;
      clk_cnt   <= '0;
      data_cnt  <= '0;
    end else begin
      if (clk_sync[1] == clk_filt) begin
        clk_cnt <= '0;
      end else if (clk_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        clk_filt <= clk_sync[1];
        clk_cnt  <= '0;
      end else begin
        clk_cnt <= clk_cnt + DEB_W'(1);
      end
      if (data_sync[1] == data_filt) begin
        data_cnt <= '0;
      end else if (data_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        data_filt <= data_sync[1];
        data_cnt  <= '0;
      end else begin
        data_cnt <= data_cnt + DEB_W'(1);
      end
    end
  end

  assign fall_c = clk_filt_q & ~clk_filt;
  assign key_c  = map_key(byte_code, shift_flag, ctrl_flag);

  // Bit capture, idle timeout and frame check producing one valid byte strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_filt_q <= 1'b1;
      frame      <= '0;
      bit_cnt    <= '0;
      idle_cnt   <= '0;
      byte_valid <= 1'b0;
      byte_code  <= '0;
    end else begin
      clk_filt_q <= clk_filt;
      byte_valid <= 1'b0;
      if (!clk_filt) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_W'(IDLE_CYCLES)) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
      if (fall_c) begin
        frame   <= {data_filt, frame[10:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end else if (bit_cnt == 4'd11) begin
        byte_valid <= ~frame[0] & frame[10] & (^frame[9:1]);
        byte_code  <= frame[8:1];
        bit_cnt    <= '0;
      end else if (idle_cnt == IDLE_W'(IDLE_CYCLES)) begin
        bit_cnt <= '0;
      end
    end
  end

  // Decoder state, modifier flags and registered ASCII output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= NORMAL;
      shift_flag <= 1'b0;
      ctrl_flag  <= 1'b0;
      ascii_code <= '0;
      ascii_new  <= 1'b0;
    end else begin
      state      <= state_n;
      shift_flag <= shift_n;
      ctrl_flag  <= ctrl_n;
      ascii_code <= code_n;
      ascii_new  <= new_n;
    end
  end

  // Scan-code decoder: prefix tracking, modifier updates and character emission.
  always_comb begin
    state_n = state;
    shift_n = shift_flag;
    ctrl_n  = ctrl_flag;
    code_n  = ascii_code;
    new_n   = 1'b0;
    if (byte_valid) begin
      if (byte_code == 8'hF0) begin
        state_n = (state == EXT || state == EXT_BREAK) ? EXT_BREAK : BREAK;
      end else if (byte_code == 8'hE0) begin
        state_n = (state == BREAK || state == EXT_BREAK) ? EXT_BREAK : EXT;
      end else begin
        state_n = NORMAL;
        case (state)
          NORMAL: begin
            if (byte_code == 8'h12 || byte_code == 8'h59) shift_n = 1'b1;
            if (byte_code == 8'h14) ctrl_n = 1'b1;
            if (key_c[7]) begin
              code_n = key_c[6:0];
              new_n  = 1'b1;
            end
          end
          BREAK: begin
            if (byte_code == 8'h12 || byte_code == 8'h59) shift_n = 1'b0;
            if (byte_code == 8'h14) ctrl_n = 1'b0;
          end
          EXT: begin
            if (byte_code == 8'h14) ctrl_n = 1'b1;
          end
          default: begin
            if (byte_code == 8'h14) ctrl_n = 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_to_ascii.sv
// Bench for ps2_keyboard_to_ascii: directed frames plus random key events,
// checked every cycle against a table-driven keyboard model.
`timescale 1ns/1ps
module tb_ps2_keyboard_to_ascii;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned DEB      = 8;
  localparam int unsigned IDLE_US  = 100;
  localparam int LAT_LO = DEB + 3;
  localparam int LAT_HI = DEB + 7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [6:0] ascii_code;
  logic       ascii_new;

  ps2_keyboard_to_ascii #(
    .CLK_FREQ(CLK_FREQ), .DEBOUNCE_CYCLES(DEB), .IDLE_US(IDLE_US)
  ) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ascii_code(ascii_code), .ascii_new(ascii_new)
  );

  always #500 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Keyboard model: character tables plus pending-prefix and modifier flags.
  logic [6:0] map_lo [logic [7:0]];
  logic [6:0] map_hi [logic [7:0]];
  logic [7:0] keys [$];
  bit m_shift, m_ctrl, m_brk, m_ext;

  typedef struct { logic [6:0] ch; int fall; } exp_t;
  exp_t exp_q [$];

  int n_checks = 0, n_fail = 0;
  int rd_idx = 0;
  logic [6:0] last_code = '0;
  bit prev_new = 1'b0;
  int req_id = 0, done_id = 0;
  string req_name;
  logic [6:0] req_want;

  function automatic bit model_byte(input logic [7:0] b, output logic [6:0] ch);
    ch = '0;
    if (b == 8'hF0) begin m_brk = 1'b1; return 1'b0; end
    if (b == 8'hE0) begin m_ext = 1'b1; return 1'b0; end
    if (m_ext) begin
      if (b == 8'h14) m_ctrl = !m_brk;
      m_ext = 1'b0; m_brk = 1'b0;
      return 1'b0;
    end
    if (m_brk) begin
      if (b == 8'h12 || b == 8'h59) m_shift = 1'b0;
      if (b == 8'h14) m_ctrl = 1'b0;
      m_brk = 1'b0;
      return 1'b0;
    end
    if (b == 8'h12 || b == 8'h59) m_shift = 1'b1;
    if (b == 8'h14) m_ctrl = 1'b1;
    if (!map_lo.exists(b)) return 1'b0;
    ch = m_shift ? map_hi[b] : map_lo[b];
    if (m_ctrl && map_lo[b] >= 7'h41 && map_lo[b] <= 7'h5A) ch = map_lo[b] - 7'h40;
    return 1'b1;
  endfunction

  // Drive frame bits first..last-1 of byte b; a complete good frame feeds the model.
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input int first,
                           input int last, input int half);
    logic [10:0] f;
    logic [6:0]  ch;
    exp_t        e;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = first; i < last; i++) begin
      ps2_data = f[i];
      #(half);
      ps2_clk = 1'b0;
      if (i == 10 && first == 0 && !bad_par) begin
        if (model_byte(b, ch)) begin
          e.ch = ch; e.fall = cyc;
          exp_q.push_back(e);
        end
      end
      #(half);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic tx(input logic [7:0] b);
    send_bits(b, 1'b0, 0, 11, int'($urandom_range(29412, 45000)));
    #(int'($urandom_range(10, 60)) * 1000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    m_shift = 1'b0; m_ctrl = 1'b0; m_brk = 1'b0; m_ext = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Hand off a literal ascii_code expectation to the compare process.
  task automatic expect_code(input string name, input logic [6:0] want);
    int guard;
    guard = 0;
    while (rd_idx != exp_q.size() && guard < 200) begin @(negedge clk); guard++; end
    @(posedge clk);
    req_name = name; req_want = want; req_id++;
    @(negedge clk);
    #1;
  endtask

  // Compare process: every pulse against the model queue, hold between pulses.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      last_code = '0; prev_new = 1'b0; rd_idx = exp_q.size();
    end else begin
      n_checks++;
      if (ascii_new) begin
        if (prev_new) begin
          n_fail++;
          $display("FAIL pulse_width: ascii_new high 2+ cycles, required 1 at cyc %0d", cyc);
        end else if (rd_idx >= exp_q.size()) begin
          n_fail++;
          $display("FAIL unexpected_pulse: got code %h, required no pulse at cyc %0d", ascii_code, cyc);
          last_code = ascii_code;
        end else begin
          e = exp_q[rd_idx]; rd_idx++;
          if (ascii_code !== e.ch || cyc - e.fall < LAT_LO || cyc - e.fall > LAT_HI) begin
            n_fail++;
            $display("FAIL char: got %h after %0d clks, required %h within %0d..%0d clks",
                     ascii_code, cyc - e.fall, e.ch, LAT_LO, LAT_HI);
          end
          last_code = e.ch;
        end
      end else begin
        if (ascii_code !== last_code) begin
          n_fail++;
          $display("FAIL hold: ascii_code %h without strobe, required %h", ascii_code, last_code);
          last_code = ascii_code;
        end
        if (rd_idx < exp_q.size() && cyc - exp_q[rd_idx].fall > LAT_HI) begin
          n_fail++;
          $display("FAIL missed_pulse: got no strobe, required %h", exp_q[rd_idx].ch);
          rd_idx++;
        end
      end
      prev_new = ascii_new;
    end
    if (req_id != done_id) begin
      n_checks++;
      if (rd_idx != exp_q.size() || ascii_code !== req_want || ascii_new !== 1'b0) begin
        n_fail++;
        $display("FAIL %s: got code %h new %b, required code %h new 0", req_name,
                 ascii_code, ascii_new, req_want);
      end
      done_id = req_id;
    end
  end

  initial begin
    logic [7:0]  let_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
    logic [7:0]  dig_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                    8'h3E, 8'h46};
    logic [7:0]  pun_codes [11] = '{8'h0E, 8'h4E, 8'h55, 8'h5D, 8'h54, 8'h5B, 8'h4C, 8'h52,
                                    8'h41, 8'h49, 8'h4A};
    logic [6:0]  pun_lo [11] = '{7'h60, 7'h2D, 7'h3D, 7'h5C, 7'h5B, 7'h5D, 7'h3B, 7'h27,
                                 7'h2C, 7'h2E, 7'h2F};
    logic [6:0]  pun_hi [11] = '{7'h7E, 7'h5F, 7'h2B, 7'h7C, 7'h7B, 7'h7D, 7'h3A, 7'h22,
                                 7'h3C, 7'h3E, 7'h3F};
    string letters = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    string dig_lo = "0123456789", dig_hi = ")!@#$%^&*(";
    int r;
    logic [7:0] k;

    for (int i = 0; i < 26; i++) begin
      map_lo[let_codes[i]] = 7'(letters[i]); map_hi[let_codes[i]] = 7'(letters[i]);
    end
    for (int i = 0; i < 10; i++) begin
      map_lo[dig_codes[i]] = 7'(dig_lo[i]); map_hi[dig_codes[i]] = 7'(dig_hi[i]);
    end
    for (int i = 0; i < 11; i++) begin
      map_lo[pun_codes[i]] = pun_lo[i]; map_hi[pun_codes[i]] = pun_hi[i];
    end
    map_lo[8'h29] = 7'h20; map_hi[8'h29] = 7'h20;
    map_lo[8'h5A] = 7'h0D; map_hi[8'h5A] = 7'h0D;
    map_lo[8'h66] = 7'h5F; map_hi[8'h66] = 7'h5F;
    map_lo[8'h76] = 7'h1B; map_hi[8'h76] = 7'h1B;
    map_lo[8'h0D] = 7'h09; map_hi[8'h0D] = 7'h09;
    foreach (map_lo[c]) keys.push_back(c);
    keys.push_back(8'h05); keys.push_back(8'h58); keys.push_back(8'h77);

    repeat (5) @(negedge clk);
    reset = 1'b0;
    #500_000;
    expect_code("reset_idle", 7'h00);

    send_bits(8'h1C, 1'b0, 0, 11, 29412); #50_000;
    expect_code("first_A", 7'h41);
    send_bits(8'h1C, 1'b0, 0, 11, 29412); #50_000;
    expect_code("typematic_A", 7'h41);

    tx(8'h12); tx(8'h16);
    expect_code("shift_1", 7'h21);
    tx(8'hF0); tx(8'h12); tx(8'h16);
    expect_code("unshift_1", 7'h31);

    send_bits(8'h1C, 1'b1, 0, 11, 30000); #50_000;
    expect_code("bad_parity", 7'h31);
    tx(8'h5A);
    expect_code("enter", 7'h0D);

    send_bits(8'h1C, 1'b0, 0, 5, 30000); #200_000;
    tx(8'h29);
    expect_code("timeout_space", 7'h20);

    tx(8'h14); tx(8'h1C);
    expect_code("ctrl_A", 7'h01);
    tx(8'hF0); tx(8'h14); tx(8'hE0); tx(8'h14); tx(8'h1A);
    expect_code("ext_ctrl_Z", 7'h1A);
    tx(8'hE0); tx(8'hF0); tx(8'h14); tx(8'h1A);
    expect_code("plain_Z", 7'h5A);
    tx(8'h66);
    expect_code("rubout", 7'h5F);
    tx(8'hE0); tx(8'h75);
    expect_code("ext_silent", 7'h5F);

    tx(8'h12);
    send_bits(8'h1C, 1'b0, 0, 5, 30000);
    do_reset();
    send_bits(8'h1C, 1'b0, 5, 11, 30000);
    #50_000;
    expect_code("reset_mid_frame", 7'h00);
    #200_000;
    tx(8'h16);
    expect_code("flags_cleared", 7'h31);

    for (int n = 0; n < 25; n++) begin
      r = int'($urandom_range(0, 9));
      k = keys[$urandom_range(0, keys.size() - 1)];
      case (r)
        0, 1, 2, 3: begin
          tx(k);
          if ($urandom_range(0, 1) == 1) begin tx(8'hF0); tx(k); end
        end
        4: tx($urandom_range(0, 1) == 1 ? 8'h12 : 8'h59);
        5: begin tx(8'hF0); tx($urandom_range(0, 1) == 1 ? 8'h12 : 8'h59); end
        6: begin if ($urandom_range(0, 1) == 1) tx(8'hE0); tx(8'h14); end
        7: begin if ($urandom_range(0, 1) == 1) tx(8'hE0); tx(8'hF0); tx(8'h14); end
        8: begin tx(8'hE0); if ($urandom_range(0, 1) == 1) tx(8'hF0); tx(8'h75); end
        default: begin send_bits(k, 1'b1, 0, 11, 35000); #40_000; end
      endcase
    end

    repeat (100) @(negedge clk);
    expect_code("final_drain", last_code);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_to_ascii.md
# ps2_keyboard_to_ascii

Receives the serial PS/2 keyboard stream (device-driven clock and data), decodes Set-2 scan codes and presents 7-bit ASCII characters with a one-cycle strobe. It is the keyboard front end of the Apple-1 system: its output feeds the keyboard data/strobe register read by the CPU. All logic runs on the single system clock. The asynchronous PS/2 lines are sampled, never used as clocks.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz; sets filter and timeout counts.
- DEBOUNCE_CYCLES, 8: consecutive identical samples required before a filtered PS/2 line changes.
- IDLE_US, 100: microseconds of ps2_clk held high that abort a partial frame.
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- ps2_clk  input  1  PS/2 clock from keyboard, asynchronous, idle high.
- ps2_data  input  1  PS/2 data from keyboard, asynchronous, idle high.
- ascii_code  output  7  last decoded ASCII character; holds until the next character.
- ascii_new  output  1  one-clk pulse when ascii_code has been updated.

## Operation
- Input conditioning: each PS/2 line passes through a 2-FF synchronizer, then a filter. The filtered value changes only after DEBOUNCE_CYCLES equal samples.
- Bit capture: on each filtered ps2_clk falling edge, sample filtered ps2_data into an 11-bit shift register, LSB first: start, D0..D7, parity, stop. Increment the bit count on each sample.
- Idle timeout: if filtered ps2_clk stays high for IDLE_US × CLK_FREQ/1e6 cycles, clear the bit count (5000 cycles at defaults).
- Frame check: after the 11th bit, the frame is valid only if start=0, stop=1 and D0..D7 plus parity has odd weight. Invalid frames are silently dropped. The bit count clears either way.
- Scan decoder states, one per received valid byte:
  - NORMAL.
  - BREAK: entered on 0xF0.
  - EXT: entered on 0xE0.
  - EXT_BREAK: entered on 0xF0 while in EXT.
- The byte following 0xF0 is a key release. Update modifier flags only, emit nothing, return to NORMAL.
- The byte following 0xE0 is an extended key. No extended key produces ASCII, so emit nothing and return to NORMAL (via EXT_BREAK for releases).
- Modifier flags:
  - shift: set on make of 0x12 or 0x59, cleared on the corresponding break.
  - ctrl: set/cleared by 0x14 and by E0 0x14.
  - Both flags clear on reset.
- Make codes emit a character. Repeated makes (typematic) emit again each time; no break is required between them.
- Letters always yield uppercase: 0x1C→0x41 'A' … 'Z'. With ctrl held, a letter yields 0x01–0x1A instead.
- Digits and punctuation (US layout) yield the unshifted or shifted glyph according to the shift flag, e.g. 0x16→'1'/'!' and 0x4E→'-'/'_'.
- Special keys:
  - 0x29 space → 0x20.
  - 0x5A Enter → 0x0D.
  - 0x66 Backspace → 0x5F '_' (Apple-1 rubout).
  - 0x76 Esc → 0x1B.
  - 0x0D Tab → 0x09.
- Unmapped make codes, modifiers, lock keys and F-keys emit nothing.

## Timing
- Reset: ascii_code=0x00 and ascii_new=0. The bit count, shift register, decoder state (NORMAL), flags, filter state and timeout counter all clear.
- A reset asserted mid-frame discards the partial frame.
- Latency: ascii_new pulses exactly 3 clks after the filtered falling edge of the stop bit (1 clk frame check, 1 clk decode, 1 clk register). It is never longer than one clk.
- ascii_code changes only in the same cycle that ascii_new is asserted, and is stable otherwise.
- No backpressure: a new character overwrites the previous one.
- Supported PS/2 clock range: 10–16.7 kHz, with each half-period ≥ 29 µs.

## Test plan
- Reset then idle lines: ascii_code=0x00, ascii_new stays 0.
- Frame 0x1C sent with 29.412 µs half-periods, parity 0, after 500 µs idle → one 1-clk ascii_new pulse, ascii_code=0x41.
- Same frame sent a second time with no 0xF0 in between → second pulse, ascii_code=0x41.
- 0x12, 0x16, then F0 12 and 0x16 → '!' (0x21), then '1' (0x31). The F0 frames produce no pulse.
- Bad parity on 0x1C (parity=1) → no pulse. A following good 0x5A frame → 0x0D.
- Stop after 5 bits, idle 200 µs, then send a full 0x29 frame → ascii_code=0x20. Separately, reset mid-frame → no pulse from that frame.
